datapath_sequencer: RTL and testbench

Drives the adder/regfile datapath's control fields from a small program buffer rather than from live logic-analyzer bits. Words are loaded one at a time. On start, the block issues one word per clock with cycle-exact timing. It captures the datapath's ALU result for every issued word into a result buffer, which the management side reads back after the run. It sits between the LA/wishbone-facing wrapper and `datapath1`, and is the producer for the control interface that `datapath1` consumes.

---
 rtl/datapath_seq_pkg.sv | 17 +
 rtl/datapath_sequencer_if.sv | 15 +
 rtl/seq_regbuf.sv | 17 +
 rtl/datapath_sequencer.sv | 98 +++++++++
 tb/tb_datapath_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared widths, control-word field positions and sequencer states
package datapath_seq_pkg;
  localparam int CTRL_W = 33;
  localparam int RES_W = 34;
  localparam int ALU_W = 32;
  localparam int ALUSRC_BIT = 32;
  localparam int ADDSUB_BIT = 31;
  localparam int RA0_MSB = 30;
  localparam int RA0_LSB = 26;
  localparam int RA1_MSB = 25;
  localparam int RA1_LSB = 21;
  localparam int WA_MSB = 20;
  localparam int WA_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: control fields issued to datapath1 and the result/flags it returns
interface datapath_sequencer_if;
  logic ALUSrc;
  logic AddSub;
  logic [4:0] RA0;
  logic [4:0] RA1;
  logic [4:0] WA;
  logic [15:0] Im;
  logic issue;
  logic [31:0] ALUout;
  logic Cout;
  logic Overflow;
  modport master (output ALUSrc, AddSub, RA0, RA1, WA, Im, issue, input ALUout, Cout, Overflow);
  modport slave (input ALUSrc, AddSub, RA0, RA1, WA, Im, issue, output ALUout, Cout, Overflow);
endinterface

// File: rtl/seq_regbuf.sv
// seq_regbuf: W x DEPTH register array, synchronous write, asynchronous read
module seq_regbuf #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: replays a loaded program into datapath1 and captures results; SEQ_FLAGS_EN keeps Cout/Overflow
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  i_load_valid,
  input  logic [CTRL_W-1:0]     i_load_word,
  output logic                  o_load_ready,
  input  logic                  i_start,
  input  logic                  i_clear,
  datapath_sequencer_if.master  dp,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_res_valid,
  output logic [RES_W-1:0]      o_res_data,
  input  logic                  i_res_rd,
  output logic                  o_ovf_seen
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef SEQ_FLAGS_EN
  localparam int BW = RES_W;
`else
  localparam int BW = ALU_W;
`endif
  seq_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, rd_q, rd_d;
  logic [PW-1:0] idx_q, idx_d, prog_ra;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, prog_rd;
  logic issue_q, issue_d, ovf_q, ovf_d;
  logic load_acc, start_ok, last;
  logic [BW-1:0] res_wd, res_rd;
  assign o_load_ready = state_q == IDLE && count_q < CW'(DEPTH);
  assign load_acc = o_load_ready && i_load_valid && !i_clear;
  assign last = {1'b0, idx_q} == count_q - CW'(1);
  assign o_res_valid = state_q == DONE && rd_q < count_q;
  assign o_res_data = state_q == DONE ? RES_W'(res_rd) : '0;
  // during RUN the buffer is already presenting the word for the following cycle
  assign prog_ra = state_q == RUN ? idx_q + PW'(1) : '0;
  assign start_ok = state_q == IDLE && i_start && count_d != '0;
`ifdef SEQ_FLAGS_EN
  assign res_wd = {dp.Cout, dp.Overflow, dp.ALUout};
  assign ovf_d = !i_clear && (ovf_q || (state_q == RUN && dp.Overflow));
`else
  logic unused_flags;
  assign unused_flags = dp.Cout ^ dp.Overflow;
  assign res_wd = dp.ALUout;
  assign ovf_d = 1'b0;
`endif
  always_comb begin
    count_d = i_clear ? '0 : count_q + CW'(load_acc);
    state_d = i_clear ? IDLE : start_ok ? RUN : (state_q == RUN && last) ? DONE : state_q;
    idx_d = (i_clear || start_ok) ? '0 : (state_q == RUN && !last) ? idx_q + PW'(1) : idx_q;
    rd_d = i_clear ? '0 : (o_res_valid && i_res_rd) ? rd_q + CW'(1) : rd_q;
    issue_d = start_ok || (state_q == RUN && !last && !i_clear);
    // a word loaded into an empty buffer on the start cycle is not yet readable
    ctrl_d = start_ok ? (count_q == '0 ? i_load_word : prog_rd) : issue_d ? prog_rd : '0;
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q <= '0;
      rd_q <= '0;
      ctrl_q <= '0;
      issue_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q <= idx_d;
      rd_q <= rd_d;
      ctrl_q <= ctrl_d;
      issue_q <= issue_d;
      ovf_q <= ovf_d;
    end
  seq_regbuf #(.W(CTRL_W), .DEPTH(DEPTH)) u_prog (
    .clk(wb_clk_i), .we(load_acc && !wb_rst_i), .waddr(count_q[PW-1:0]),
    .wdata(i_load_word), .raddr(prog_ra), .rdata(prog_rd)
  );
  seq_regbuf #(.W(BW), .DEPTH(DEPTH)) u_res (
    .clk(wb_clk_i), .we(state_q == RUN && !wb_rst_i), .waddr(idx_q),
    .wdata(res_wd), .raddr(rd_q[PW-1:0]), .rdata(res_rd)
  );
  assign dp.ALUSrc = ctrl_q[ALUSRC_BIT];
  assign dp.AddSub = ctrl_q[ADDSUB_BIT];
  assign dp.RA0 = ctrl_q[RA0_MSB:RA0_LSB];
  assign dp.RA1 = ctrl_q[RA1_MSB:RA1_LSB];
  assign dp.WA = ctrl_q[WA_MSB:WA_LSB];
  assign dp.Im = ctrl_q[IM_MSB:IM_LSB];
  assign dp.issue = issue_q;
  assign o_busy = state_q == RUN;
  assign o_done = state_q == DONE;
  assign o_ovf_seen = ovf_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: scoreboard bench with a stub datapath1 deriving ALUout/flags from the issued word
module tb_datapath_sequencer;
  import datapath_seq_pkg::*;
  localparam int DEPTH = 8;
`ifdef SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  logic clk = 0, rst = 1, load_valid = 0, start = 0, clear = 0, res_rd = 0;
  logic [CTRL_W-1:0] load_word = '0;
  logic load_ready, busy, done, res_valid, ovf_seen;
  logic [RES_W-1:0] res_data;
  int vectors = 0, miscompares = 0;
  logic [CTRL_W-1:0] expq [$];
  logic [RES_W-1:0] resq [$];
  datapath_sequencer_if dp ();
  assign dp.ALUout = dp.issue ? ({dp.AddSub, dp.RA0, dp.RA1, dp.WA, dp.Im} ^ 32'h5A5A1234) : 32'hDEADBEEF;
  assign dp.Cout = dp.issue & dp.Im[0];
  assign dp.Overflow = dp.issue && dp.Im == 16'hBEEF;
  always #5 clk = ~clk;
  datapath_sequencer #(.DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .i_load_valid(load_valid), .i_load_word(load_word),
    .o_load_ready(load_ready), .i_start(start), .i_clear(clear), .dp(dp.master),
    .o_busy(busy), .o_done(done), .o_res_valid(res_valid), .o_res_data(res_data),
    .i_res_rd(res_rd), .o_ovf_seen(ovf_seen)
  );
  function automatic logic [CTRL_W-1:0] mk(logic s, logic a, logic [4:0] r0, logic [4:0] r1, logic [4:0] wa, logic [15:0] im);
    return {s, a, r0, r1, wa, im};
  endfunction
  function automatic logic [RES_W-1:0] res_of(logic [CTRL_W-1:0] w);
    logic [31:0] alu;
    alu = w[31:0] ^ 32'h5A5A1234;
    return FLAGS ? {w[0], w[15:0] == 16'hBEEF, alu} : {2'b00, alu};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic load(logic [CTRL_W-1:0] w);
    @(negedge clk);
    check("load_ready", load_ready, 1);
    load_valid = 1;
    load_word = w;
    expq.push_back(w);
    @(negedge clk);
    load_valid = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic do_clear();
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    expq.delete();
    resq.delete();
  endtask
  task automatic check_issue();
    logic [CTRL_W-1:0] w;
    check("issue", dp.issue, 1);
    check("busy", busy, 1);
    if (expq.size() == 0) check("expq_size", expq.size(), 1);
    else begin
      w = expq.pop_front();
      check("ctrl", {dp.ALUSrc, dp.AddSub, dp.RA0, dp.RA1, dp.WA, dp.Im}, w);
      resq.push_back(res_of(w));
    end
  endtask
  task automatic expect_issues(int n);
    for (int k = 0; k < n; k++) begin
      check_issue();
      @(negedge clk);
    end
    check("issue_end", dp.issue, 0);
    check("done", done, 1);
    check("busy_end", busy, 0);
  endtask
  task automatic read_all(int n);
    for (int k = 0; k < n; k++) begin
      check("res_valid", res_valid, 1);
      if (resq.size() == 0) check("resq_size", resq.size(), 1);
      else check("res_data", res_data, resq.pop_front());
      res_rd = 1;
      @(negedge clk);
      res_rd = 0;
    end
    check("res_valid_end", res_valid, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_issue", dp.issue, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ovf", ovf_seen, 0);
    check("rst_ready", load_ready, 1);
    // basic three-word run
    load(mk(0, 0, 5'd1, 5'd2, 5'd3, 16'h0000));
    load(mk(0, 1, 5'd4, 5'd5, 5'd6, 16'h0000));
    load(mk(1, 0, 5'd1, 5'd0, 5'd7, 16'h0005));
    pulse_start();
    expect_issues(3);
    read_all(3);
    check("basic_ovf", ovf_seen, 0);
    do_clear();
    // full buffer, ninth word refused
    for (int k = 0; k < DEPTH; k++) load({1'(k & 1), 32'($urandom())});
    @(negedge clk);
    check("full_ready", load_ready, 0);
    load_valid = 1;
    load_word = mk(1, 1, 5'd31, 5'd31, 5'd31, 16'hFFFF);
    @(negedge clk);
    load_valid = 0;
    pulse_start();
    expect_issues(DEPTH);
    read_all(DEPTH);
    do_clear();
    // start with empty program
    pulse_start();
    repeat (3) begin
      check("empty_issue", dp.issue, 0);
      check("empty_busy", busy, 0);
      check("empty_done", done, 0);
      @(negedge clk);
    end
    // abort on second issue cycle of a 5-word run
    for (int k = 0; k < 5; k++) load(mk(0, 1, 5'(k), 5'(k + 1), 5'(k + 2), 16'(k * 3)));
    pulse_start();
    check_issue();
    @(negedge clk);
    check_issue();
    clear = 1;
    @(negedge clk);
    clear = 0;
    expq.delete();
    resq.delete();
    check("abort_issue", dp.issue, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", load_ready, 1);
    load(mk(0, 0, 5'd9, 5'd10, 5'd11, 16'h1234));
    pulse_start();
    expect_issues(1);
    read_all(1);
    do_clear();
    // load accepted in the start cycle joins the run
    load(mk(0, 0, 5'd2, 5'd3, 5'd4, 16'h00A0));
    load(mk(1, 1, 5'd5, 5'd6, 5'd7, 16'h00A1));
    @(negedge clk);
    load_valid = 1;
    start = 1;
    load_word = mk(0, 1, 5'd8, 5'd9, 5'd10, 16'h00A2);
    expq.push_back(load_word);
    @(negedge clk);
    load_valid = 0;
    start = 0;
    expect_issues(3);
    read_all(3);
    do_clear();
    // same, into an empty buffer
    @(negedge clk);
    load_valid = 1;
    start = 1;
    load_word = mk(1, 0, 5'd12, 5'd13, 5'd14, 16'h7777);
    expq.push_back(load_word);
    @(negedge clk);
    load_valid = 0;
    start = 0;
    expect_issues(1);
    read_all(1);
    do_clear();
    // overflow on word 1 only
    load(mk(0, 0, 5'd1, 5'd2, 5'd3, 16'h0002));
    load(mk(0, 1, 5'd1, 5'd2, 5'd3, 16'hBEEF));
    load(mk(0, 0, 5'd3, 5'd3, 5'd3, 16'h0010));
    pulse_start();
    check_issue();
    @(negedge clk);
    check("ovf_before", ovf_seen, 0);
    check_issue();
    @(negedge clk);
    check("ovf_after", ovf_seen, FLAGS);
    expect_issues(1);
    check("ovf_done", ovf_seen, FLAGS);
    read_all(3);
    check("ovf_hold", ovf_seen, FLAGS);
    do_clear();
    check("ovf_cleared", ovf_seen, 0);
    check("clear_ready", load_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
